// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_ctrl_pkg;

  // Controller phases: idle, first (load) pass, optional verify pass, one-cycle done.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Number of host words needed to cover one full pass of the chain.
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-to-loader bitstream stream (valid/ready, one word per accepted edge).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader_word_serializer.sv
// Single-word buffer that serialises host words LSB-first onto the chain head.
// The ready rule keeps the buffered plus shifted bit total below the chain
// length, so a pass never accepts a word it cannot start shifting.
module ccff_word_serializer #(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  parameter  int CNT_W     = $clog2(CHAIN_LEN + 1),
  localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active_i,
  input  logic             test_en_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] bit_count_i,
  ccff_chain_loader_if.slave s_if,
  output logic             shift_o,
  output logic             head_o
);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;

  logic              shift;
  logic              last_bit;
  logic              accept;
  logic [31:0]       fill;

  assign shift    = active_i && valid_q && !test_en_i;
  assign last_bit = shift && (idx_q == IDX_W'(WORD_W - 1));
  // Bits already shifted this pass plus bits still waiting in the buffer.
  assign fill     = 32'(bit_count_i) + (valid_q ? (32'(WORD_W) - 32'(idx_q)) : 32'd0);

  assign s_if.s_ready = active_i && (!valid_q || last_bit) && (fill < 32'(CHAIN_LEN));
  assign accept       = s_if.s_valid && s_if.s_ready;

  assign shift_o = shift;
  assign head_o  = shift ? buf_q[idx_q] : 1'b0;

  // Buffer next state: pass end discards leftovers, a new word reloads, a shift advances.
  always_comb begin
    buf_d   = buf_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (accept) begin
      buf_d   = s_if.s_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (shift) begin
      if (last_bit) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller: loads the CCFF chain from a host stream and
// optionally re-sends the stream while checking what falls out of the tail.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  input  logic             Test_en,
  input  logic             start,
  input  logic             verify_en,
  ccff_chain_loader_if.slave s_if,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  state_e           state_q, state_d;
  logic             verify_q, verify_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic             shift;
  logic             pass_end;

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  // The shift that brings the count to CHAIN_LEN closes the current pass.
  assign pass_end = shift && (bit_count_q == CNT_W'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .CNT_W     (CNT_W)
  ) u_serializer (
    .clk         (prog_clk),
    .rst_n       (prog_reset_n),
    .active_i    (busy),
    .test_en_i   (Test_en),
    .flush_i     (pass_end),
    .bit_count_i (bit_count_q),
    .s_if        (s_if),
    .shift_o     (shift),
    .head_o      (ccff_head)
  );

  assign ccff_shift_en = shift;
  assign done          = (state_q == ST_DONE);
  assign error         = error_q;
  assign bit_count     = bit_count_q;

  // Phase sequencing, per-pass bit counting and tail-versus-head compare.
  always_comb begin
    state_d     = state_q;
    verify_d    = verify_q;
    error_d     = error_q;
    bit_count_d = bit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          verify_d    = verify_en;
          error_d     = 1'b0;
          bit_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (shift) begin
          bit_count_d = bit_count_q + CNT_W'(1);
        end
        if (pass_end) begin
          if (verify_q) begin
            state_d     = ST_VERIFY;
            bit_count_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_VERIFY: begin
        if (shift) begin
          bit_count_d = bit_count_q + CNT_W'(1);
          if (ccff_tail != ccff_head) begin
            error_d = 1'b1;
          end
        end
        if (pass_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers with synchronous active-low reset; reset aborts any pass.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q     <= ST_IDLE;
      verify_q    <= 1'b0;
      error_q     <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      verify_q    <= verify_d;
      error_q     <= error_d;
      bit_count_q <= bit_count_d;
    end
  end

endmodule
